// File: rtl/bgm_player.sv
`default_nettype none
// ============================================================================
// Module   : bgm_player
// Purpose  : Reads 12-bit note words (H[11:4] half-period code, B[3:0] beats)
//            from a synchronous ROM and drives a square-wave buzzer.
//            Define BGM_LOOP_EN to restart the song instead of stopping.
// Revision : 1.0 - initial release
// ============================================================================
module bgm_player #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 12,
    parameter int BEAT_CYCLES = 12500000,
    parameter int TONE_UNIT   = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  buzzer,
    output logic                  playing,
    output logic                  done
);

    localparam int c_CYC_W  = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int c_TONE_W = 8 + $clog2(TONE_UNIT + 1);
    localparam logic [c_CYC_W-1:0]  c_CYC_LAST  = c_CYC_W'(BEAT_CYCLES - 1);
    localparam logic [c_TONE_W-1:0] c_TONE_UNIT = c_TONE_W'(TONE_UNIT);
`ifdef BGM_LOOP_EN
    localparam logic c_LOOP = 1'b1;
`else
    localparam logic c_LOOP = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_half;
    logic [3:0]            r_beats;
    logic [3:0]            r_beat_cnt;
    logic [c_CYC_W-1:0]    r_cyc_cnt;
    logic [c_TONE_W-1:0]   r_tone_cnt;
    logic                  r_phase;
    logic                  r_rom_en;
    logic                  r_buzzer;
    logic                  r_playing;
    logic                  r_done;

    logic [c_TONE_W-1:0]   w_tone_last;
    logic [3:0]            w_beats_in;
    logic                  w_beat_wrap;
    logic                  w_note_end;
    logic                  w_tone_wrap;
    logic                  w_phase_next;
    logic                  w_song_over;

    assign w_tone_last  = c_TONE_W'(r_half) * c_TONE_UNIT - c_TONE_W'(1);
    assign w_beats_in   = (rom_data[3:0] == 4'd0) ? 4'd1 : rom_data[3:0];
    assign w_beat_wrap  = (r_cyc_cnt == c_CYC_LAST);
    assign w_note_end   = w_beat_wrap && ((r_beat_cnt + 4'd1) == r_beats);
    assign w_tone_wrap  = (r_half != 8'd0) && (r_tone_cnt == w_tone_last);
    // The phase survives a pause; only the visible buzzer is gated.
    assign w_phase_next = (r_half != 8'd0) && (r_phase ^ w_tone_wrap);
    assign w_song_over  = ((r_state == S_LATCH) && (rom_data == '0)) ||
                          ((r_state == S_PLAY) && !pause && w_note_end && (r_addr == '1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_half     <= 8'd0;
            r_beats    <= 4'd0;
            r_beat_cnt <= 4'd0;
            r_cyc_cnt  <= '0;
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
            r_rom_en   <= 1'b0;
            r_buzzer   <= 1'b0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rom_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr    <= '0;
                        r_rom_en  <= 1'b1;
                        r_playing <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    r_half     <= rom_data[11:4];
                    r_beats    <= w_beats_in;
                    r_beat_cnt <= 4'd0;
                    r_cyc_cnt  <= '0;
                    r_tone_cnt <= '0;
                    r_phase    <= 1'b0;
                    r_buzzer   <= 1'b0;
                    r_state    <= S_PLAY;
                end
                S_PLAY: begin
                    if (pause) begin
                        r_buzzer <= 1'b0;
                    end else begin
                        r_cyc_cnt <= w_beat_wrap ? '0 : r_cyc_cnt + c_CYC_W'(1);
                        if (w_beat_wrap) begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                        r_tone_cnt <= (r_half == 8'd0 || w_tone_wrap) ? '0 : r_tone_cnt + c_TONE_W'(1);
                        r_phase    <= w_phase_next;
                        r_buzzer   <= w_phase_next;
                        if (w_note_end) begin
                            r_buzzer <= 1'b0;
                            r_addr   <= r_addr + ADDR_WIDTH'(1);
                            r_rom_en <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_END:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // End marker or address wrap: restart or stop, overriding the above.
            if (w_song_over) begin
                r_buzzer <= 1'b0;
                if (c_LOOP) begin
                    r_addr   <= '0;
                    r_rom_en <= 1'b1;
                    r_state  <= S_FETCH;
                end else begin
                    r_addr    <= r_addr;
                    r_rom_en  <= 1'b0;
                    r_done    <= 1'b1;
                    r_playing <= 1'b0;
                    r_state   <= S_END;
                end
            end
        end
    end

    assign rom_en   = r_rom_en;
    assign rom_addr = r_addr;
    assign buzzer   = r_buzzer;
    assign playing  = r_playing;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bgm_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_bgm_player
// Purpose  : Randomized and directed bench for bgm_player against a
//            note-level reference model (elapsed-cycle arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bgm_player;

    localparam int c_AW    = 4;
    localparam int c_DW    = 12;
    localparam int c_BEAT  = 10;
    localparam int c_TU    = 2;
    localparam int c_DEPTH = 1 << c_AW;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_LATCH = 2;
    localparam int M_PLAY  = 3;
    localparam int M_END   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            pause;
    logic            rom_en;
    logic [c_AW-1:0] rom_addr;
    logic [c_DW-1:0] rom_data;
    logic            buzzer;
    logic            playing;
    logic            done;

    logic [11:0] mem [c_DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase of the song and active cycles elapsed in the note.
    int m_st;
    int m_addr;
    int m_h;
    int m_b;
    int m_k;
    bit m_pz;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    bgm_player #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .BEAT_CYCLES(c_BEAT),
        .TONE_UNIT  (c_TU)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .buzzer  (buzzer),
        .playing (playing),
        .done    (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic song_over();
`ifdef BGM_LOOP_EN
        m_addr = 0;
        m_st   = M_FETCH;
`else
        m_st   = M_END;
`endif
    endtask

    task automatic model_step(input logic s, input logic p, input logic r);
        logic [11:0] w;
        m_pz = 1'b0;
        if (r) begin
            m_st = M_IDLE; m_addr = 0; m_h = 0; m_b = 0; m_k = 0;
        end else begin
            case (m_st)
                M_IDLE:  if (s) begin m_addr = 0; m_st = M_FETCH; end
                M_FETCH: m_st = M_LATCH;
                M_LATCH: begin
                    w = mem[m_addr];
                    if (w == 12'h000) song_over();
                    else begin
                        m_h  = int'(w[11:4]);
                        m_b  = (w[3:0] == 4'd0) ? 1 : int'(w[3:0]);
                        m_k  = 0;
                        m_st = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (p) m_pz = 1'b1;
                    else begin
                        m_k++;
                        if (m_k == m_b * c_BEAT) begin
                            if (m_addr == c_DEPTH - 1) song_over();
                            else begin m_addr++; m_st = M_FETCH; end
                        end
                    end
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    function automatic int exp_buz();
        if (m_st != M_PLAY || m_pz || m_h == 0) return 0;
        return (m_k / (m_h * c_TU)) % 2;
    endfunction

    task automatic tick(input logic s, input logic p, input logic r);
        @(negedge clk);
        start = s; pause = p; rst = r;
        @(posedge clk);
        model_step(s, p, r);
        #1;
        check("rom_en",   int'(rom_en),   int'(m_st == M_FETCH));
        check("rom_addr", int'(rom_addr), m_addr);
        check("playing",  int'(playing),  int'(m_st == M_FETCH || m_st == M_LATCH || m_st == M_PLAY));
        check("done",     int'(done),     int'(m_st == M_END));
        check("buzzer",   int'(buzzer),   exp_buz());
    endtask

    task automatic load4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
        for (int i = 0; i < c_DEPTH; i++) mem[i] = 12'h000;
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    // One start pulse, then run until the model is idle again (or budget ends).
    task automatic run_song(input int budget, input int pause_pct, input int pfrom,
                            input int plen, input int rst_at,
                            output int play_cycles, output int done_cnt);
        int  cyc;
        logic p, s, r;
        if (m_st != M_IDLE) tick(1'b0, 1'b0, 1'b1);
        play_cycles = 0;
        done_cnt    = 0;
        tick(1'b1, 1'b0, 1'b0);
        play_cycles += int'(playing);
        cyc = 1;
        while (cyc < budget && m_st != M_IDLE) begin
            p = (cyc >= pfrom && cyc < pfrom + plen) || ($urandom_range(99) < pause_pct);
            s = (m_st != M_END) && ($urandom_range(99) < 3);
            r = (cyc == rst_at);
            tick(s, p, r);
            play_cycles += int'(playing);
            done_cnt    += int'(done);
            cyc++;
        end
`ifndef BGM_LOOP_EN
        check("song_finished", int'(playing), 0);
`endif
    endtask

    initial begin
        int pc;
        int dc;
        rst = 1'b1; start = 1'b0; pause = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) mem[i] = 12'h000;
        m_st = M_IDLE; m_addr = 0; m_h = 0; m_b = 0; m_k = 0; m_pz = 1'b0;

        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);

`ifdef BGM_LOOP_EN
        load4(12'h021, 12'h000, 12'h000, 12'h000);
        run_song(150, 0, 0, 0, -1, pc, dc);
        check("loop_done", dc, 0);
        check("loop_playing", int'(playing), 1);
`endif

        load4(12'h053, 12'h000, 12'h000, 12'h000);
        run_song(200, 0, 0, 0, -1, pc, dc);
`ifndef BGM_LOOP_EN
        check("t1_play_len", pc, 34);
        check("t1_done_cnt", dc, 1);
`endif

        load4(12'h002, 12'h031, 12'h000, 12'h000);
        run_song(200, 0, 0, 0, -1, pc, dc);
`ifndef BGM_LOOP_EN
        check("rest_play_len", pc, 36);
        check("rest_done_cnt", dc, 1);
`endif

        load4(12'h010, 12'h000, 12'h000, 12'h000);
        run_song(200, 0, 0, 0, -1, pc, dc);
`ifndef BGM_LOOP_EN
        check("b0_play_len", pc, 14);
`endif

        load4(12'h013, 12'h000, 12'h000, 12'h000);
        run_song(200, 0, 12, 7, -1, pc, dc);
`ifndef BGM_LOOP_EN
        check("pause_play_len", pc, 41);
`endif

        load4(12'h053, 12'h000, 12'h000, 12'h000);
        run_song(200, 0, 0, 0, 15, pc, dc);
        check("rst_no_done", dc, 0);
        check("rst_playing", int'(playing), 0);
        check("rst_addr", int'(rom_addr), 0);
        run_song(200, 0, 0, 0, -1, pc, dc);
`ifndef BGM_LOOP_EN
        check("restart_play_len", pc, 34);
`endif

        for (int i = 0; i < c_DEPTH; i++) mem[i] = 12'h011;
        run_song(300, 0, 0, 0, -1, pc, dc);
`ifndef BGM_LOOP_EN
        check("wrap_play_len", pc, 192);
        check("wrap_done_cnt", dc, 1);
`endif

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(5, 1);
            for (int i = 0; i < c_DEPTH; i++) mem[i] = 12'h000;
            for (int i = 0; i < n; i++)
                mem[i] = {8'($urandom_range(6, 0)), 4'($urandom_range(3, 0))};
            run_song(600, 15, 0, 0, -1, pc, dc);
`ifndef BGM_LOOP_EN
            check("rand_done_cnt", dc, 1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bgm_player.md
Name: bgm_player

Overview:
- Sequencer that reads background-music note words from a synchronous block ROM and turns them into a square-wave buzzer drive.
- It is the reader side of the BGM ROM: it drives `rom_en`/`rom_addr` and consumes `rom_data`, which arrives one cycle after the address.
- It sits between the game control FSM (start/pause/done) and the buzzer pin.

Parameters:
- ADDR_WIDTH, 16, width of the ROM address bus.
- DATA_WIDTH, 12, width of a ROM note word. The field layout below requires 12.
- BEAT_CYCLES, 12500000, clock cycles per beat (0.125 s at 100 MHz).
- TONE_UNIT, 200, clock cycles per half-period code step.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins playback from address 0
- pause  in  1  level; freezes playback while high
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH  ROM read data, registered, valid 1 cycle after `rom_en`
- buzzer  out  1  square-wave output
- playing  out  1  high from the first FETCH until entering END/IDLE
- done  out  1  single-cycle pulse when the song ends

Behaviour:
- Note word format:
  - [11:4] = half-period code H. H = 0 means rest.
  - [3:0] = beat count B. B = 0 is treated as 1.
  - Word 12'h000 = end-of-song marker.
- Reset: `rom_en`=0, `rom_addr`=0, `buzzer`=0, `playing`=0, `done`=0, state IDLE, all counters 0.
- States:
  - IDLE: waits for `start`=1, then clears the address to 0 and goes to FETCH.
  - FETCH: `rom_en`=1 for exactly one cycle with the current `rom_addr`; goes to LATCH.
  - LATCH: samples `rom_data`.
    - Word == 0: go to END.
    - Otherwise: load H and B, clear the tone and beat counters, set `buzzer`=0, go to PLAY.
  - PLAY:
    - Cycle counter counts 0..BEAT_CYCLES-1. At wrap, the beat counter increments.
    - When the beat counter reaches B, `rom_addr` increments and the state goes to FETCH.
    - Tone counter counts 0..H*TONE_UNIT-1. At its terminal value, `buzzer` toggles and the counter clears.
    - When H=0, `buzzer` is held 0 and the tone counter stays 0.
  - END: `done`=1 for one cycle, `playing`=0, then IDLE.
- Latency:
  - `start` sampled at edge N: FETCH during cycle N+1, LATCH during N+2.
  - The first tone cycle is N+3.
  - Gap between notes is 2 cycles (FETCH + LATCH), with `buzzer` forced 0 during the gap.
- `rom_en` is high only in FETCH. `rom_addr` is stable from FETCH through PLAY.
- Arithmetic widths:
  - The tone limit H*TONE_UNIT is computed at 8+clog2(TONE_UNIT+1) bits.
  - The beat counter is 4 bits.
  - The cycle counter is clog2(BEAT_CYCLES) bits.
- Pause: while `pause`=1 in PLAY, all counters hold and `buzzer` is forced 0.
  - On release, counting resumes where it stopped and `buzzer` resumes from its pre-pause phase.
  - Pause in FETCH/LATCH takes effect from the next PLAY cycle.
  - Pause in IDLE has no effect.
- `start` while `playing`=1 is ignored.
- Address wrap (last note at address 2^ADDR_WIDTH-1 completes): treated as end-of-song, go to END.
- `rst` asserted in any state returns all outputs to reset values on the next edge, with no `done` pulse.

Optional Feature:
- Macro BGM_LOOP_EN.
- Defined:
  - End-of-song marker or address wrap sets `rom_addr`=0 and goes to FETCH. END is skipped and `done` never pulses.
  - `playing` stays 1 until `rst`.
- Undefined: behaviour as above (stop, `done` pulse, IDLE).

Test Plan (BEAT_CYCLES=10, TONE_UNIT=2):
- ROM {0x053, 0x000}, `start` pulse → `rom_en` at addr 0 on cycle 1; `buzzer` toggles every 10 cycles for 30 cycles; then addr 1 fetched, `done` pulses once, `playing`=0.
- ROM {0x002, 0x031, 0x000} → `buzzer`=0 for 20 cycles (rest); then toggles every 6 cycles for 10 cycles; then `done`.
- ROM {0x010, 0x000} (B=0) → one note of exactly 10 PLAY cycles, toggling every 2 cycles.
- During a 3-beat note, `pause` high for 7 cycles → `buzzer`=0 while paused; note ends 7 cycles later than unpaused; phase continues.
- `rst` asserted mid-PLAY → next cycle `buzzer`=0, `rom_en`=0, `rom_addr`=0, `playing`=0, no `done`; a second `start` restarts at addr 0.
- With BGM_LOOP_EN, ROM {0x021, 0x000} → addr sequence 0,1,0,1…; `done` never asserts; `start` pulses mid-play are ignored.
